// File: rtl/bubble_data_sequencer.sv
// Bubble data sequencer: tracks the emulated loop position, fetches the
// matching bit from the page buffer and drives it out on each strobe fall.
module bubble_data_sequencer #(
    parameter int   LOOP_LENGTH = 2053,
    parameter int   POS_WIDTH   = 12,
    parameter logic IDLE_BIT    = 1'b0
) (
    input  logic                 master_clock,
    input  logic                 master_reset,
    input  logic                 position_change,
    input  logic                 position_latch,
    input  logic                 page_select,
    input  logic                 data_out_notice,
    input  logic                 data_out_strobe,
    input  logic                 coil_enable,
    output logic                 read_request,
    output logic [POS_WIDTH:0]   read_address,
    input  logic                 read_ack,
    input  logic                 read_data,
    output logic                 bubble_out,
    output logic [POS_WIDTH-1:0] latched_position,
    output logic                 position_valid,
    output logic                 fetch_miss
);

    localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(LOOP_LENGTH - 1);
    localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_e;

    logic                 chg_q, lat_q, ntc_q, stb_q;
    logic                 chg_rise, lat_rise, ntc_rise, stb_fall;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic [POS_WIDTH-1:0] lpos_q, lpos_d;
    logic                 pvalid_q, pvalid_d;
    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [POS_WIDTH:0]   addr_q, addr_d;
    logic                 held_q, held_d;
    logic                 bout_q, bout_d;
    logic                 miss_q, miss_d;

    assign chg_rise = position_change & ~chg_q;
    assign lat_rise = position_latch & ~lat_q;
    assign ntc_rise = data_out_notice & ~ntc_q;
    assign stb_fall = ~data_out_strobe & stb_q;

    always_comb begin
        pos_d    = pos_q;
        lpos_d   = lpos_q;
        pvalid_d = pvalid_q;
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        held_d   = held_q;
        bout_d   = bout_q;
        miss_d   = miss_q;

        // Stopped coils freeze the loop even if the generator still pulses.
        if (chg_rise && !coil_enable) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        end

        if (lat_rise) begin
            lpos_d   = pos_q;
            pvalid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ntc_rise) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = {page_select, pos_d};
                end
            end
            REQ: begin
                // A strobe fall wins over a same-cycle ack.
                if (stb_fall) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    miss_d  = 1'b1;
                    bout_d  = IDLE_BIT;
                end else if (read_ack) begin
                    state_d = HOLD;
                    req_d   = 1'b0;
                    held_d  = read_data;
                end
            end
            HOLD: begin
                if (stb_fall) begin
                    state_d = IDLE;
                    bout_d  = held_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge master_clock or posedge master_reset) begin
        if (master_reset) begin
            chg_q    <= 1'b0;
            lat_q    <= 1'b0;
            ntc_q    <= 1'b0;
            stb_q    <= 1'b0;
            pos_q    <= '0;
            lpos_q   <= '0;
            pvalid_q <= 1'b0;
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            held_q   <= IDLE_BIT;
            bout_q   <= IDLE_BIT;
            miss_q   <= 1'b0;
        end else begin
            chg_q    <= position_change;
            lat_q    <= position_latch;
            ntc_q    <= data_out_notice;
            stb_q    <= data_out_strobe;
            pos_q    <= pos_d;
            lpos_q   <= lpos_d;
            pvalid_q <= pvalid_d;
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            held_q   <= held_d;
            bout_q   <= bout_d;
            miss_q   <= miss_d;
        end
    end

    assign read_request     = req_q;
    assign read_address     = addr_q;
    assign bubble_out       = bout_q;
    assign latched_position = lpos_q;
    assign position_valid   = pvalid_q;
    assign fetch_miss       = miss_q;

endmodule

// File: tb/tb_bubble_data_sequencer.sv
// Testbench for bubble_data_sequencer: directed cases plus randomized
// operations checked against a position/fetch reference model.
module tb_bubble_data_sequencer;

    localparam int   LOOP = 2053;
    localparam int   PW   = 12;
    localparam logic IB   = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pc = 1'b0, pl = 1'b0, ps = 1'b0;
    logic          ntc = 1'b0, stb = 1'b0, coil = 1'b0;
    logic          ack = 1'b0, rdata = 1'b0;
    logic          req, bout, pvalid, miss;
    logic [PW:0]   addr;
    logic [PW-1:0] lpos;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pos = 0;
    int m_lat = 0;
    bit m_valid = 0;
    bit m_miss = 0;
    bit m_bout = IB;

    always #5 clk = ~clk;

    bubble_data_sequencer #(
        .LOOP_LENGTH(LOOP),
        .POS_WIDTH  (PW),
        .IDLE_BIT   (IB)
    ) dut (
        .master_clock    (clk),
        .master_reset    (rst),
        .position_change (pc),
        .position_latch  (pl),
        .page_select     (ps),
        .data_out_notice (ntc),
        .data_out_strobe (stb),
        .coil_enable     (coil),
        .read_request    (req),
        .read_address    (addr),
        .read_ack        (ack),
        .read_data       (rdata),
        .bubble_out      (bout),
        .latched_position(lpos),
        .position_valid  (pvalid),
        .fetch_miss      (miss)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int adv(input int p);
        return (p == LOOP - 1) ? 0 : p + 1;
    endfunction

    task automatic pulse_pc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) pc = 1'b1;
            @(negedge clk) pc = 1'b0;
            if (!coil) m_pos = adv(m_pos);
        end
    endtask

    task automatic do_latch(input bit with_pc);
        @(negedge clk);
        pl = 1'b1;
        pc = with_pc;
        @(negedge clk);
        pl = 1'b0;
        pc = 1'b0;
        m_lat   = m_pos;
        m_valid = 1'b1;
        if (with_pc && !coil) m_pos = adv(m_pos);
        check("latched_position", 32'(lpos), 32'(m_lat));
        check("position_valid", 32'(pvalid), 32'(m_valid));
    endtask

    task automatic strobe_pulse();
        @(negedge clk) stb = 1'b1;
        @(negedge clk) stb = 1'b0;
    endtask

    // mode 0: ack before strobe fall, 1: ack on the fall cycle, 2: no ack
    task automatic do_fetch(input bit page, input bit collide, input int mode,
                            input int dly, input bit data);
        logic [PW:0] exp_addr;
        @(negedge clk);
        ps  = page;
        ntc = 1'b1;
        pc  = collide;
        if (collide && !coil) m_pos = adv(m_pos);
        exp_addr = {page, PW'(m_pos)};
        @(negedge clk);
        ntc = 1'b0;
        pc  = 1'b0;
        check("req_on", 32'(req), 32'd1);
        check("read_address", 32'(addr), 32'(exp_addr));
        repeat (dly) @(negedge clk);
        check("addr_frozen", 32'(addr), 32'(exp_addr));
        if (mode == 0) begin
            ack   = 1'b1;
            rdata = data;
            @(negedge clk);
            ack   = 1'b0;
            rdata = ~data;
            check("req_drop", 32'(req), 32'd0);
            check("bout_hold", 32'(bout), 32'(m_bout));
            @(negedge clk) ntc = 1'b1;
            @(negedge clk) ntc = 1'b0;
            strobe_pulse();
            @(negedge clk);
            m_bout = data;
            check("bout_hit", 32'(bout), 32'(m_bout));
            check("req_ignored_ntc", 32'(req), 32'd0);
        end else begin
            @(negedge clk) stb = 1'b1;
            @(negedge clk);
            stb = 1'b0;
            if (mode == 1) begin
                ack   = 1'b1;
                rdata = ~IB;
            end
            @(negedge clk);
            ack    = 1'b0;
            m_bout = IB;
            m_miss = 1'b1;
            check("bout_miss", 32'(bout), 32'(m_bout));
            check("req_miss", 32'(req), 32'd0);
            if (mode == 2) begin
                rdata = ~IB;
                @(negedge clk) ack = 1'b1;
                @(negedge clk) ack = 1'b0;
                strobe_pulse();
                @(negedge clk);
                check("late_ack", 32'(bout), 32'(m_bout));
            end
        end
        check("fetch_miss", 32'(miss), 32'(m_miss));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_bout", 32'(bout), 32'(IB));
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_valid", 32'(pvalid), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;

        // Wrap around the loop end
        pulse_pc(LOOP - 1);
        do_latch(1'b0);
        pulse_pc(1);
        do_latch(1'b0);

        // Stopped coils
        pulse_pc(3);
        coil = 1'b1;
        pulse_pc(5);
        do_latch(1'b0);
        coil = 1'b0;

        // Normal fetch at pos 7, page 1 -> 13'h1007
        pulse_pc(4);
        do_fetch(1'b1, 1'b0, 0, 2, 1'b1);
        check("addr_1007", 32'(dut.addr_q), 32'h1007);

        // Miss, then a normal fetch
        do_fetch(1'b0, 1'b0, 2, 1, 1'b0);
        do_fetch(1'b0, 1'b0, 0, 0, 1'b1);
        do_fetch(1'b1, 1'b0, 1, 3, 1'b1);

        // Collision at pos 40
        pulse_pc(33);
        do_latch(1'b1);
        do_fetch(1'b0, 1'b1, 0, 1, 1'b0);
        check("collide_idx", 32'(addr[PW-1:0]), 32'd42);

        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                coil = ($urandom_range(0, 3) == 0);
                pulse_pc(int'($urandom_range(1, 40)));
                coil = 1'b0;
            end else if (op == 1) begin
                do_latch(1'($urandom_range(0, 1)));
            end else begin
                do_fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 4)),
                         1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset in the middle of a request
        pulse_pc(9);
        do_fetch(1'b0, 1'b0, 0, 0, 1'b1);
        @(negedge clk) ntc = 1'b1;
        @(negedge clk) ntc = 1'b0;
        check("pre_rst_req", 32'(req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(req), 32'd0);
        check("arst_bout", 32'(bout), 32'(IB));
        check("arst_miss", 32'(miss), 32'd0);
        check("arst_valid", 32'(pvalid), 32'd0);
        @(negedge clk) rst = 1'b0;
        m_pos   = 0;
        m_miss  = 1'b0;
        m_bout  = IB;
        do_latch(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bubble_data_sequencer.md
Name: bubble_data_sequencer

Overview:
- Sits directly downstream of the timing generator and consumes its position_change, position_latch, page_select, data_out_notice, data_out_strobe and coil_enable outputs.
- Tracks the emulated bubble loop position and fetches the matching bit from the page buffer through a request/acknowledge port.
- Presents each fetched bit on the emulated detector output at the falling edge of data_out_strobe.
- Flags any fetch that misses its strobe window.

Parameters:
- LOOP_LENGTH, 2053: number of bubble positions per minor-loop rotation; position counter wraps at LOOP_LENGTH-1.
- POS_WIDTH, 12: width of the position counter and of the bit-index part of read_address; must satisfy 2^POS_WIDTH >= LOOP_LENGTH.
- IDLE_BIT, 1'b0: value driven on bubble_out after reset and on a fetch miss.

Ports:
- master_clock  in  1  48MHz system clock; all timing generator inputs are synchronous to it.
- master_reset  in  1  asynchronous, active-high reset.
- position_change  in  1  active high; each rising edge advances the bubble position by one.
- position_latch  in  1  active high; rising edge captures the current position.
- page_select  in  1  program page select; forms read_address MSB.
- data_out_notice  in  1  active high; rising edge starts a fetch.
- data_out_strobe  in  1  active high; falling edge presents data.
- coil_enable  in  1  active low; high means coils stopped.
- read_request  out  1  fetch request to the page buffer.
- read_address  out  POS_WIDTH+1  {page_select, position}.
- read_ack  in  1  one-cycle acknowledge from the page buffer; read_data is valid in the same cycle.
- read_data  in  1  fetched bubble bit.
- bubble_out  out  1  emulated detector data bit.
- latched_position  out  POS_WIDTH  position captured at the last position_latch rise.
- position_valid  out  1  set by the first position_latch rise after reset.
- fetch_miss  out  1  sticky miss flag.

Behaviour:
- Reset values (all applied asynchronously on master_reset high): position=0, latched_position=0, position_valid=0, read_request=0, read_address=0, bubble_out=IDLE_BIT, fetch_miss=0, FSM=IDLE, all edge-detect registers=0.
- Edge detection: one previous-value register per input. rise = cur & ~prev; fall = ~cur & prev. Edges are seen one cycle after the input changes.
- Position counter:
  - On position_change rise, pos <= (pos==LOOP_LENGTH-1) ? 0 : pos+1.
  - The counter holds whenever coil_enable is high, even if a position_change rise occurs.
- Latch: on position_latch rise, latched_position <= pos and position_valid <= 1. If a position_change rise occurs in the same cycle, the pre-increment pos is captured.
- Fetch FSM with states IDLE, REQ, HOLD:
  - IDLE: on data_out_notice rise, go to REQ with read_request=1 and read_address={page_select, pos}. If a position_change rise occurs in the same cycle, read_address uses the post-increment value. read_address is frozen until the FSM leaves REQ.
  - REQ: read_request stays high. On read_ack, register read_data into an internal holding bit, drop read_request, go to HOLD. Acknowledge latency is unbounded.
  - REQ on data_out_strobe fall without an ack: fetch_miss<=1, bubble_out<=IDLE_BIT, read_request<=0, go to IDLE. An ack arriving in that same cycle counts as a miss and its data is discarded.
  - HOLD: on data_out_strobe fall, bubble_out<=held bit, go to IDLE.
  - A new data_out_notice rise while in REQ or HOLD is ignored.
- bubble_out holds its value between strobes and changes only at a data_out_strobe fall or at reset.
- fetch_miss stays set until master_reset.
- Stop/restart: when coil_enable goes high in REQ or HOLD, the FSM still completes normally on the next strobe fall. No strobe edges arrive while stopped, so the FSM stays where it is.
- read_ack outside REQ is ignored.

Test Plan:
- Reset: assert master_reset mid-REQ -> read_request=0, bubble_out=IDLE_BIT, position=0, fetch_miss=0, asynchronously.
- Wrap: LOOP_LENGTH=2053, coil_enable low, 2053 position_change pulses -> position returns to 0; 2052 pulses then position_latch -> latched_position=2052, position_valid=1.
- Stopped coils: coil_enable high, 5 position_change pulses -> position unchanged.
- Normal fetch: page_select=1, pos=7, notice rise -> read_address=13'h1007 with read_request=1; read_ack with read_data=1 two cycles later -> bubble_out=1 one cycle after the strobe falling edge.
- Miss: no read_ack before the strobe fall -> bubble_out=0, fetch_miss=1 and sticky; a later ack is ignored; the next fetch completes normally.
- Collision: position_change rise and position_latch rise in the same cycle at pos=40 -> latched_position=40, pos=41; notice rise together with position_change rise at pos=41 -> read_address bit index=42.
